// File: rtl/aes_decipher_arbiter.sv
// aes_decipher_arbiter
// Shares one aes_decipher_block between two requesters. Jobs are granted
// round-robin, latched, and sent to the core with a one-cycle next pulse.
// The arbiter waits for the core to drop ready and then raise it again, and
// returns the result tagged with the requester id. A watchdog ends a stalled
// job with an error response. Round keys come from the key memory and are
// not handled here.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   req{0,1}_valid/ready  job handshake; ready is combinational, grantee only
//   req{0,1}_block/keylen ciphertext and key length (0=AES-128, 1=AES-256)
//   core_next             one-cycle start pulse to the decipher core
//   core_block/keylen     registered job operands, stable for the whole job
//   core_ready/result     core idle/done flag and plaintext
//   resp_valid/ready      response handshake
//   resp_data/id/err      plaintext (zero on error), owner, watchdog error
//   busy                  high whenever the arbiter is not idle
module aes_decipher_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_block,
    input  logic         req0_keylen,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_block,
    input  logic         req1_keylen,
    output logic         core_next,
    output logic         core_keylen,
    output logic [127:0] core_block,
    input  logic         core_ready,
    input  logic [127:0] core_result,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [127:0] resp_data,
    output logic         resp_id,
    output logic         resp_err,
    output logic         busy
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] RESP      = 3'd4;

    // Counter value seen on the last permitted wait cycle.
    localparam logic [10:0] WD_LAST = 11'(TIMEOUT_CYCLES - 1);

    logic [2:0]   state_q, state_d;
    logic         rr_last_q, rr_last_d;
    logic [127:0] block_q, block_d;
    logic         keylen_q, keylen_d;
    logic         id_q, id_d;
    logic [127:0] resp_data_q, resp_data_d;
    logic         resp_err_q, resp_err_d;
    logic [10:0]  wd_cnt_q, wd_cnt_d;

    logic grant_any;
    logic grant_id;
    logic wd_expire;

    always_comb begin
        grant_any = req0_valid | req1_valid;
        // With both requesting, the one that did not win last time goes next.
        if (req0_valid && req1_valid) begin
            grant_id = ~rr_last_q;
        end else begin
            grant_id = req1_valid;
        end
        wd_expire = (wd_cnt_q == WD_LAST);
    end

    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        block_d     = block_q;
        keylen_d    = keylen_q;
        id_d        = id_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        wd_cnt_d    = wd_cnt_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    block_d    = grant_id ? req1_block : req0_block;
                    keylen_d   = grant_id ? req1_keylen : req0_keylen;
                    id_d       = grant_id;
                    rr_last_d  = grant_id;
                    state_d    = START;
                end
            end
            START: begin
                wd_cnt_d = '0;
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                wd_cnt_d = wd_cnt_q + 11'd1;
                if (wd_expire) begin
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                    state_d     = RESP;
                end else if (!core_ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                wd_cnt_d = wd_cnt_q + 11'd1;
                // Watchdog wins over a completion arriving in the same cycle.
                if (wd_expire) begin
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                    state_d     = RESP;
                end else if (core_ready) begin
                    resp_data_d = core_result;
                    resp_err_d  = 1'b0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_err_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_last_q   <= 1'b1;
            block_q     <= '0;
            keylen_q    <= 1'b0;
            id_q        <= 1'b0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            wd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            block_q     <= block_d;
            keylen_q    <= keylen_d;
            id_q        <= id_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            wd_cnt_q    <= wd_cnt_d;
        end
    end

    assign core_next   = (state_q == START);
    assign core_block  = block_q;
    assign core_keylen = keylen_q;
    assign resp_valid  = (state_q == RESP);
    assign resp_data   = resp_data_q;
    assign resp_id     = id_q;
    assign resp_err    = resp_err_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_aes_decipher_arbiter.sv
// Testbench for aes_decipher_arbiter: a stub decipher core with programmable
// latency feeds the arbiter; expected grants, results and latencies come from
// a round-robin / timing model of the intended behaviour.
module tb_aes_decipher_arbiter;

    localparam int TIMEOUT = 1024;
    localparam logic [127:0] FIPS_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [127:0] req0_block = '0, req1_block = '0;
    logic         req0_keylen = 1'b0, req1_keylen = 1'b0;
    logic         core_next, core_keylen;
    logic [127:0] core_block;
    logic         core_ready = 1'b1;
    logic [127:0] core_result = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [127:0] resp_data;
    logic         resp_id, resp_err, busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit rr_model = 1'b1;    // last grantee, as the arbiter should remember it
    int core_lat = 2;       // extra cycles the stub core stays busy
    bit stub_stuck = 1'b0;  // core ignores next and keeps ready high
    int stub_cnt = 0;
    int next_pulses = 0;
    int next_double = 0;
    logic next_prev = 1'b0;

    aes_decipher_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_block (req0_block),
        .req0_keylen(req0_keylen),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_block (req1_block),
        .req1_keylen(req1_keylen),
        .core_next  (core_next),
        .core_keylen(core_keylen),
        .core_block (core_block),
        .core_ready (core_ready),
        .core_result(core_result),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the decipher core: FIPS vectors decrypt correctly,
    // anything else maps through a fixed scramble.
    function automatic logic [127:0] ref_core(input logic [127:0] b, input logic k);
        if (b == FIPS_C1 && !k) return FIPS_PT;
        if (b == FIPS_C3 && k) return FIPS_PT;
        return {b[63:0], b[127:64]} ^ {4{k ? 32'hc3a5_5a3c : 32'h1357_9bdf}};
    endfunction

    always @(posedge clk) begin
        if (core_next && !stub_stuck) begin
            core_ready  <= 1'b0;
            stub_cnt    <= core_lat;
            core_result <= ref_core(core_block, core_keylen);
        end else if (!core_ready) begin
            if (stub_cnt == 0) core_ready <= 1'b1;
            else stub_cnt <= stub_cnt - 1;
        end
    end

    always @(posedge clk) begin
        next_prev <= core_next;
        if (core_next) next_pulses++;
        if (core_next && next_prev) next_double++;
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Runs one job from an idle arbiter, entered and left just after a negedge.
    task automatic do_job(input string tag, input logic v0, input logic v1,
                          input logic [127:0] b0, input logic [127:0] b1,
                          input logic k0, input logic k1,
                          input int hold, input bit keep, input bit exp_err);
        logic         eg, ek;
        logic [1:0]   er;
        logic [127:0] eb, ed;
        int           n, want_n;
        req0_valid = v0; req0_block = b0; req0_keylen = k0;
        req1_valid = v1; req1_block = b1; req1_keylen = k1;
        #1;
        eg = (v0 && v1) ? ~rr_model : v1;
        er = eg ? 2'b10 : 2'b01;
        n_cmp++;
        if ({req1_ready, req0_ready} !== er) begin
            n_bad++;
            $display("FAIL %s grant: got ready1/0=%b want %b", tag, {req1_ready, req0_ready}, er);
        end
        rr_model = eg;
        eb = eg ? b1 : b0;
        ek = eg ? k1 : k0;
        ed = exp_err ? 128'd0 : ref_core(eb, ek);
        @(negedge clk);
        if (!keep) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        #1;
        n_cmp++;
        if ({core_next, busy, req1_ready, req0_ready} !== 4'b1100) begin
            n_bad++;
            $display("FAIL %s start: got next/busy/rdy=%b want 1100",
                     tag, {core_next, busy, req1_ready, req0_ready});
        end
        n_cmp++;
        if ({core_keylen, core_block} !== {ek, eb}) begin
            n_bad++;
            $display("FAIL %s operands: got %b %h want %b %h", tag, core_keylen, core_block, ek, eb);
        end
        n = 0;
        while (resp_valid !== 1'b1 && n < TIMEOUT + 64) begin
            @(negedge clk);
            n++;
        end
        // Error: 1 START cycle + TIMEOUT wait cycles. Normal: WAIT_BUSY cycle,
        // core busy for core_lat+1 cycles, one cycle to register the result.
        want_n = exp_err ? TIMEOUT + 1 : core_lat + 3;
        n_cmp++;
        if (n !== want_n) begin
            n_bad++;
            $display("FAIL %s latency: got %0d cycles want %0d", tag, n, want_n);
        end
        n_cmp++;
        if ({resp_err, resp_id, resp_data} !== {exp_err, eg, ed}) begin
            n_bad++;
            $display("FAIL %s response: got err=%b id=%b data=%h want err=%b id=%b data=%h",
                     tag, resp_err, resp_id, resp_data, exp_err, eg, ed);
        end
        for (int i = 0; i < hold; i++) begin
            if (!keep) begin
                req0_valid = 1'($urandom);
                req1_valid = 1'($urandom);
            end
            @(negedge clk);
            #1;
            n_cmp++;
            if ({resp_valid, resp_err, resp_id, resp_data, req1_ready, req0_ready} !==
                {1'b1, exp_err, eg, ed, 2'b00}) begin
                n_bad++;
                $display("FAIL %s hold: got v=%b err=%b id=%b data=%h rdy=%b want v=1 id=%b data=%h",
                         tag, resp_valid, resp_err, resp_id, resp_data,
                         {req1_ready, req0_ready}, eg, ed);
            end
        end
        if (!keep) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        #1;
        n_cmp++;
        if ({resp_valid, busy, resp_err} !== 3'b000) begin
            n_bad++;
            $display("FAIL %s release: got valid/busy/err=%b want 000", tag, {resp_valid, busy, resp_err});
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({busy, resp_valid, core_next, req0_ready, req1_ready, resp_id, resp_err,
             core_keylen, resp_data, core_block} !== '0) begin
            n_bad++;
            $display("FAIL reset: got busy=%b rv=%b next=%b rdy=%b%b err=%b data=%h blk=%h want all 0",
                     busy, resp_valid, core_next, req1_ready, req0_ready, resp_err,
                     resp_data, core_block);
        end
        @(negedge clk);
        reset = 1'b0;
        rr_model = 1'b1;
    endtask

    task automatic test_fips();
        core_lat = 5;
        do_job("fips128", 1'b1, 1'b0, FIPS_C1, rand128(), 1'b0, 1'b1, 0, 1'b0, 1'b0);
        do_job("fips256", 1'b0, 1'b1, rand128(), FIPS_C3, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int p0, d0;
        core_lat = 3;
        p0 = next_pulses;
        d0 = next_double;
        for (int i = 0; i < 4; i++) begin
            do_job("b2b", 1'b1, 1'b1, rand128(), rand128(), 1'($urandom), 1'($urandom),
                   0, 1'b1, 1'b0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (next_pulses - p0 !== 4 || next_double - d0 !== 0) begin
            n_bad++;
            $display("FAIL b2b next pulses: got %0d pulses %0d doubled want 4 and 0",
                     next_pulses - p0, next_double - d0);
        end
    endtask

    task automatic test_stall();
        core_lat = 1;
        do_job("stall", 1'b1, 1'b1, rand128(), rand128(), 1'b1, 1'b0, 20, 1'b0, 1'b0);
    endtask

    task automatic test_watchdog();
        stub_stuck = 1'b1;
        do_job("watchdog", 1'b1, 1'b0, rand128(), rand128(), 1'b0, 1'b0, 2, 1'b0, 1'b1);
        stub_stuck = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0] r;
        for (int i = 0; i < 10; i++) begin
            r = 2'($urandom_range(1, 3));
            core_lat = $urandom_range(0, 15);
            do_job("random", r[0], r[1], rand128(), rand128(), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 3), 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_midjob();
        int n;
        core_lat = 20;
        req0_valid = 1'b1;
        req0_block = rand128();
        req0_keylen = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy, resp_valid, core_next} !== 3'b000) begin
            n_bad++;
            $display("FAIL midjob reset: got busy/rv/next=%b want 000", {busy, resp_valid, core_next});
        end
        @(negedge clk);
        reset = 1'b0;
        rr_model = 1'b1;
        n = 0;
        while (core_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (core_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midjob idle: got core_ready=%b busy=%b want 1 0", core_ready, busy);
        end
        core_lat = 4;
        do_job("after_reset", 1'b1, 1'b1, FIPS_C1, rand128(), 1'b0, 1'b1, 0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_fips();
        test_back_to_back();
        test_stall();
        test_watchdog();
        test_random();
        test_reset_midjob();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
